trace_capture_ctrl: RTL and testbench

TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

---
 rtl/trace_ctrl_pkg.sv | 12 +
 rtl/trace_wr_ptr.sv | 34 +++
 rtl/trace_capture_ctrl.sv | 90 +++++++++
 tb/tb_trace_capture_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_ctrl_pkg.sv
// Shared constants for the trace capture controller: FSM encodings and the
// default trace buffer address width.
package trace_ctrl_pkg;

  localparam int TRACE_ADDR_WIDTH = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/trace_wr_ptr.sv
// Circular write pointer for the trace buffer, with a sticky wrap flag and a
// saturating count of stored samples.
module trace_wr_ptr
  import trace_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  wrapped,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Count stops at the buffer depth; once full, every new sample replaces one.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr     <= '0;
      wrapped <= 1'b0;
      count   <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_WIDTH'(1);
      if (&ptr)
        wrapped <= 1'b1;
      if (count != FULL)
        count <= count + (ADDR_WIDTH + 1)'(1);
    end
  end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: stores strobed samples into a circular BRAM,
// stops a programmable number of samples after a trigger, and maps host reads.
module trace_capture_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sample_valid,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_trig_len,
  input  logic [ADDR_WIDTH-1:0] host_rd_idx,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  output logic [1:0]            state,
  output logic                  capture_done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH:0]   sample_count
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] oldest;
  logic [1:0]            state_next;
  logic                  wrapped;
  logic                  store;
  logic                  trig_hit;
  logic                  clear;

  // abort and arm both pre-empt any sample arriving in the same cycle.
  assign store    = (state == ST_ARMED || state == ST_POST) && sample_valid && !abort && !arm;
  assign trig_hit = store && (state == ST_ARMED) && trigger;
  assign clear    = arm && !abort;
  assign oldest   = wrapped ? wr_ptr : '0;

  trace_wr_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .inc    (store),
    .ptr    (wr_ptr),
    .wrapped(wrapped),
    .count  (sample_count)
  );

  always_comb begin
    state_next = state;
    if (abort)
      state_next = ST_IDLE;
    else if (arm)
      state_next = ST_ARMED;
    else if (trig_hit)
      state_next = (post_trig_len == '0) ? ST_DONE : ST_POST;
    else if (store && state == ST_POST && post_cnt == ADDR_WIDTH'(1))
      state_next = ST_DONE;
  end

  // The sample that drains the post counter is still written on the DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      capture_done <= 1'b0;
      bram_we      <= 1'b0;
      bram_wr_addr <= '0;
      bram_rd_addr <= '0;
      trig_addr    <= '0;
      post_cnt     <= '0;
    end else begin
      state        <= state_next;
      capture_done <= (state_next == ST_DONE);
      bram_we      <= store;
      if (store)
        bram_wr_addr <= wr_ptr;
      bram_rd_addr <= oldest + host_rd_idx;
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        post_cnt  <= post_trig_len;
      end else if (store && state == ST_POST) begin
        post_cnt <= post_cnt - ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Testbench for trace_capture_ctrl: directed capture scenarios plus random
// traffic, all compared every cycle against a behavioural capture model.
module tb_trace_capture_ctrl;
  import trace_ctrl_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          abort;
  logic          sample_valid;
  logic          trigger;
  logic [AW-1:0] post_trig_len;
  logic [AW-1:0] host_rd_idx;
  logic          bram_we;
  logic [AW-1:0] bram_wr_addr;
  logic [AW-1:0] bram_rd_addr;
  logic [1:0]    state;
  logic          capture_done;
  logic [AW-1:0] trig_addr;
  logic [AW:0]   sample_count;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int m_state, m_ptr, m_wrapped, m_count, m_trig, m_remaining, m_we, m_wa, m_rd;

  trace_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .sample_valid (sample_valid),
    .trigger      (trigger),
    .post_trig_len(post_trig_len),
    .host_rd_idx  (host_rd_idx),
    .bram_we      (bram_we),
    .bram_wr_addr (bram_wr_addr),
    .bram_rd_addr (bram_rd_addr),
    .state        (state),
    .capture_done (capture_done),
    .trig_addr    (trig_addr),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit ab, input bit sv, input bit tr,
                               input int len, input int idx);
    @(negedge clk);
    rst           = r;
    arm           = a;
    abort         = ab;
    sample_valid  = sv;
    trigger       = tr;
    post_trig_len = AW'(len);
    host_rd_idx   = AW'(idx);
  endtask

  // Behavioural model of the capture: a circular buffer of DEPTH entries, a
  // trigger mark and a count of post-trigger samples still owed.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_ptr = 0; m_wrapped = 0; m_count = 0; m_trig = 0;
      m_remaining = 0; m_we = 0; m_wa = 0; m_rd = 0;
    end else begin
      m_rd = ((m_wrapped != 0 ? m_ptr : 0) + int'(host_rd_idx)) % DEPTH;
      m_we = 0;
      if (abort) begin
        m_state = 0;
      end else if (arm) begin
        m_state = 1; m_ptr = 0; m_wrapped = 0; m_count = 0;
      end else if (sample_valid && (m_state == 1 || m_state == 2)) begin
        m_we = 1;
        m_wa = m_ptr;
        if (m_state == 1 && trigger) begin
          m_trig      = m_ptr;
          m_remaining = int'(post_trig_len);
          m_state     = (m_remaining == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_remaining--;
          if (m_remaining == 0) m_state = 3;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_ptr == 0) m_wrapped = 1;
        if (m_count < DEPTH) m_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("state", 32'(state), 32'(m_state));
      checkOutput("capture_done", 32'(capture_done), 32'(m_state == 3));
      checkOutput("bram_we", 32'(bram_we), 32'(m_we));
      if (m_we != 0) checkOutput("bram_wr_addr", 32'(bram_wr_addr), 32'(m_wa));
      checkOutput("bram_rd_addr", 32'(bram_rd_addr), 32'(m_rd));
      checkOutput("trig_addr", 32'(trig_addr), 32'(m_trig));
      checkOutput("sample_count", 32'(sample_count), 32'(m_count));
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    post_trig_len = '0; host_rd_idx = '0;
    @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_state", 32'(state), 32'(ST_IDLE));
    checkOutput("reset_we", 32'(bram_we), 0);
    checkOutput("reset_count", 32'(sample_count), 0);
    checkOutput("reset_rd_addr", 32'(bram_rd_addr), 0);

    $display("[TB] basic capture, trigger on 3rd sample");
    applyStimulus(0, 1, 0, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, i == 2, 2, 0);
    applyStimulus(0, 0, 0, 0, 0, 2, 0);
    checkOutput("basic_state", 32'(state), 32'(ST_DONE));
    checkOutput("basic_done", 32'(capture_done), 1);
    checkOutput("basic_trig", 32'(trig_addr), 2);
    checkOutput("basic_count", 32'(sample_count), 5);
    checkOutput("basic_last_we", 32'(bram_we), 1);
    checkOutput("basic_last_addr", 32'(bram_wr_addr), 4);

    $display("[TB] wrapped capture");
    applyStimulus(0, 1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 1, 1, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("wrap_trig", 32'(trig_addr), 4);
    checkOutput("wrap_last_addr", 32'(bram_wr_addr), 7);
    checkOutput("wrap_state", 32'(state), 32'(ST_DONE));
    checkOutput("wrap_count", 32'(sample_count), 16);
    applyStimulus(0, 0, 0, 0, 0, 3, 5);
    checkOutput("wrap_rd_idx0", 32'(bram_rd_addr), 8);
    applyStimulus(0, 0, 0, 1, 1, 3, 0);
    checkOutput("wrap_rd_idx5", 32'(bram_rd_addr), 13);
    checkOutput("done_ignores_strobe", 32'(bram_we), 0);

    $display("[TB] trigger on first sample, zero post length");
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("zero_state", 32'(state), 32'(ST_DONE));
    checkOutput("zero_count", 32'(sample_count), 1);
    checkOutput("zero_we", 32'(bram_we), 1);
    checkOutput("zero_addr", 32'(bram_wr_addr), 0);

    $display("[TB] abort during post-trigger phase");
    applyStimulus(0, 1, 0, 0, 0, 4, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 4, 0);
    applyStimulus(0, 0, 0, 1, 1, 4, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 0, 4, 0);
    applyStimulus(0, 0, 1, 1, 0, 4, 0);
    applyStimulus(0, 0, 0, 1, 1, 4, 0);
    checkOutput("abort_state", 32'(state), 32'(ST_IDLE));
    checkOutput("abort_we", 32'(bram_we), 0);
    checkOutput("abort_trig", 32'(trig_addr), 3);
    checkOutput("abort_count", 32'(sample_count), 6);
    applyStimulus(0, 0, 0, 0, 0, 4, 0);
    checkOutput("idle_strobe_we", 32'(bram_we), 0);

    $display("[TB] reset during armed capture");
    applyStimulus(0, 1, 0, 0, 0, 4, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 0, 4, 0);
    applyStimulus(1, 0, 0, 1, 0, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 4, 0);
    checkOutput("rst_we", 32'(bram_we), 0);
    checkOutput("rst_state", 32'(state), 32'(ST_IDLE));
    checkOutput("rst_wr_addr", 32'(bram_wr_addr), 0);
    checkOutput("rst_trig", 32'(trig_addr), 0);
    checkOutput("rst_count", 32'(sample_count), 0);
    checkOutput("rst_done", 32'(capture_done), 0);

    $display("[TB] re-arm while in post-trigger phase");
    applyStimulus(0, 1, 0, 0, 0, 4, 0);
    applyStimulus(0, 0, 0, 1, 1, 4, 0);
    applyStimulus(0, 0, 0, 1, 0, 4, 0);
    applyStimulus(0, 1, 0, 1, 0, 4, 0);
    applyStimulus(0, 0, 0, 1, 0, 4, 0);
    checkOutput("rearm_state", 32'(state), 32'(ST_ARMED));
    checkOutput("rearm_we", 32'(bram_we), 0);
    checkOutput("rearm_count", 32'(sample_count), 0);
    applyStimulus(0, 0, 0, 0, 0, 4, 0);
    checkOutput("rearm_next_we", 32'(bram_we), 1);
    checkOutput("rearm_next_addr", 32'(bram_wr_addr), 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0, int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DEPTH - 1)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
